host_port_arbiter: RTL

HOST_PORT_ARBITER -- requirements
Module: host_port_arbiter

---
 rtl/host_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/host_port_arbiter.sv
// Two-requester round-robin front end that feeds apb_bridge_top.
// Optional ARB_LOCK_EN lets the owner hold its grant back-to-back.
module host_port_arbiter (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_lock,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_slverr,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_lock,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_slverr,
  output logic        br_valid,
  output logic [31:0] br_addr,
  output logic [31:0] br_wdata,
  output logic [3:0]  br_wstrb,
  input  logic        br_ready,
  input  logic [31:0] br_rdata,
  input  logic        br_slverr,
  output logic        grant_id,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        br_valid_q, br_valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        grant_q, grant_d;
  logic        ptr_q, ptr_d;

  logic        pick;
  logic        sel;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        own_valid;
  logic        own_lock;
  logic        keep_own;

  // ptr_q holds the last served requester; on a tie the other one wins
  assign pick = (m0_valid & m1_valid) ? ~ptr_q : m1_valid;

  assign sel       = (state_q == IDLE) ? pick : grant_q;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign sel_wstrb = sel ? m1_wstrb : m0_wstrb;

  assign own_valid = grant_q ? m1_valid : m0_valid;
  assign own_lock  = grant_q ? m1_lock  : m0_lock;

`ifdef ARB_LOCK_EN
  assign keep_own = own_lock & own_valid;
`else
  logic unused_lock;
  assign unused_lock = own_lock ^ own_valid;
  assign keep_own    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    br_valid_d = br_valid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (m0_valid | m1_valid) begin
          state_d    = BUSY;
          br_valid_d = 1'b1;
          grant_d    = pick;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          wstrb_d    = sel_wstrb;
        end
      end
      BUSY: begin
        if (br_ready) begin
          if (keep_own) begin
            // locked: reload the owner's next request, pointer untouched
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            wstrb_d = sel_wstrb;
          end else begin
            state_d    = IDLE;
            br_valid_d = 1'b0;
            ptr_d      = grant_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      br_valid_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      grant_q    <= 1'b0;
      ptr_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      br_valid_q <= br_valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign grant_id = grant_q;
  assign br_valid = br_valid_q;
  assign br_addr  = addr_q;
  assign br_wdata = wdata_q;
  assign br_wstrb = wstrb_q;

  assign m0_ready  = br_ready & busy & ~grant_q;
  assign m1_ready  = br_ready & busy & grant_q;
  assign m0_rdata  = {32{m0_ready}} & br_rdata;
  assign m1_rdata  = {32{m1_ready}} & br_rdata;
  assign m0_slverr = m0_ready & br_slverr;
  assign m1_slverr = m1_ready & br_slverr;

endmodule
